// File: rtl/axis_rx_frame_buffer.sv
// AXI-Stream slave that captures one TLAST-terminated frame into a word buffer,
// holds it until the consumer acknowledges, and serves a registered read port.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready, buffer empty, waiting for the first beat of a frame
// RECV   | at least one beat accepted, waiting for TLAST
// DONE   | frame complete, TREADY low until FRAME_ACK
module axis_rx_frame_buffer #(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [31:0]       axis_tdata_i,
    input  logic              axis_tkeep_i,
    input  logic              axis_tlast_i,
    output logic              axis_tready_o,
    input  logic [3:0]        axis_tstrb_i,
    input  logic              axis_tvalid_i,
    output logic              frame_done_o,
    output logic [ADDR_W:0]   frame_len_o,
    output logic              overflow_o,
    input  logic              frame_ack_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [31:0]       rd_data_o
);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_DONE} state_t;

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              ovf_q, ovf_d;
    logic              tready_q, tready_d;
    logic [31:0]       rd_data_q;
    logic [31:0]       mem_q [2**ADDR_W];

    logic accept, full, store;
    logic unused_tkeep;

    assign unused_tkeep = axis_tkeep_i;
    assign accept       = axis_tvalid_i & tready_q;
    assign full         = wr_ptr_q[ADDR_W];
    assign store        = accept & ~full;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        len_d    = len_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_RECV: begin
                if (accept) begin
                    // wr_ptr is zero in IDLE, so the length restarts from the first beat
                    wr_ptr_d = full ? wr_ptr_q : wr_ptr_q + ONE;
                    len_d    = full ? DEPTH : wr_ptr_q + ONE;
                    ovf_d    = ((state_q == S_RECV) & ovf_q) | full;
                    state_d  = axis_tlast_i ? S_DONE : S_RECV;
                end
            end
            S_DONE: begin
                if (frame_ack_i) begin
                    state_d  = S_IDLE;
                    wr_ptr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        tready_d = (state_d != S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            len_q    <= '0;
            ovf_q    <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            len_q    <= len_d;
            ovf_q    <= ovf_d;
            tready_q <= tready_d;
        end
    end

    // Buffer has no reset; only strobed bytes are overwritten.
    always_ff @(posedge clk_i) begin
        if (store) begin
            for (int b = 0; b < 4; b++) begin
                if (axis_tstrb_i[b]) begin
                    mem_q[wr_ptr_q[ADDR_W-1:0]][8*b +: 8] <= axis_tdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign axis_tready_o = tready_q;
    assign frame_done_o  = (state_q == S_DONE);
    assign frame_len_o   = len_q;
    assign overflow_o    = ovf_q;
    assign rd_data_o     = rd_data_q;

endmodule

// File: tb/tb_axis_rx_frame_buffer.sv
// Bench for axis_rx_frame_buffer: a full-depth instance and an ADDR_W=2 instance
// share the clock, reset and beat payload; each has its own handshake and read port.
module tb_axis_rx_frame_buffer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic        tlast = 1'b0;
    logic        tkeep = 1'b1;

    logic        a_tvalid = 1'b0, a_ack = 1'b0, a_tready, a_done, a_ovf;
    logic [9:0]  a_rd_addr = '0;
    logic [10:0] a_len;
    logic [31:0] a_rd_data;

    logic        b_tvalid = 1'b0, b_ack = 1'b0, b_tready, b_done, b_ovf;
    logic [1:0]  b_rd_addr = '0;
    logic [2:0]  b_len;
    logic [31:0] b_rd_data;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl_a [1024];
    logic [31:0] mdl_b [4];
    logic [31:0] sb [$];

    typedef struct {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        int          exp_len;
        logic        exp_done;
        logic        exp_tready;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;

    axis_rx_frame_buffer #(.ADDR_W(10)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .axis_tdata_i(tdata), .axis_tkeep_i(tkeep), .axis_tlast_i(tlast),
        .axis_tready_o(a_tready), .axis_tstrb_i(tstrb), .axis_tvalid_i(a_tvalid),
        .frame_done_o(a_done), .frame_len_o(a_len), .overflow_o(a_ovf),
        .frame_ack_i(a_ack), .rd_addr_i(a_rd_addr), .rd_data_o(a_rd_data)
    );

    axis_rx_frame_buffer #(.ADDR_W(2)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .axis_tdata_i(tdata), .axis_tkeep_i(tkeep), .axis_tlast_i(tlast),
        .axis_tready_o(b_tready), .axis_tstrb_i(tstrb), .axis_tvalid_i(b_tvalid),
        .frame_done_o(b_done), .frame_len_o(b_len), .overflow_o(b_ovf),
        .frame_ack_i(b_ack), .rd_addr_i(b_rd_addr), .rd_data_o(b_rd_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one beat on instance sel, wait (bounded) for acceptance, update the model.
    task automatic beat(input int sel, input logic [31:0] d, input logic [3:0] s,
                        input logic l, input int idx);
        logic ok;
        ok = 1'b0;
        tdata = d; tstrb = s; tlast = l;
        if (sel == 0) a_tvalid = 1'b1; else b_tvalid = 1'b1;
        for (int n = 0; n < 20 && !ok; n++) begin
            ok = (sel == 0) ? a_tready : b_tready;
            tick();
        end
        a_tvalid = 1'b0; b_tvalid = 1'b0; tlast = 1'b0; tdata = 32'hCCCC_CCCC;
        if (!ok) begin
            total++; bad++;
            $display("FAIL beat_timeout: got tready=0 want tready=1 (sel %0d idx %0d)", sel, idx);
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    if (sel == 0 && idx < 1024) mdl_a[idx][8*b +: 8] = d[8*b +: 8];
                    if (sel == 1 && idx < 4)    mdl_b[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end
    endtask

    task automatic rd(input int sel, input int addr);
        sb.push_back(sel == 0 ? mdl_a[addr] : mdl_b[addr]);
        if (sel == 0) a_rd_addr = 10'(addr); else b_rd_addr = 2'(addr);
        tick();
        chk($sformatf("rd_data[%0d][%0d]", sel, addr), sel == 0 ? a_rd_data : b_rd_data,
            sb.pop_front());
    endtask

    task automatic ack(input int sel);
        if (sel == 0) a_ack = 1'b1; else b_ack = 1'b1;
        tick();
        a_ack = 1'b0; b_ack = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tready"}, 32'(a_tready), 0);
        chk({tag, "_done"},   32'(a_done), 0);
        chk({tag, "_len"},    32'(a_len), 0);
        chk({tag, "_ovf"},    32'(a_ovf), 0);
        chk({tag, "_rdata"},  a_rd_data, 0);
    endtask

    initial begin
        vecs[0] = '{32'h1111_1111, 4'hF, 1'b0, 1, 1'b0, 1'b1};
        vecs[1] = '{32'h2222_2222, 4'hF, 1'b0, 2, 1'b0, 1'b1};
        vecs[2] = '{32'h3333_3333, 4'hF, 1'b0, 3, 1'b0, 1'b1};
        vecs[3] = '{32'h4444_4444, 4'hF, 1'b1, 4, 1'b1, 1'b0};

        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        chk("tready_after_rst", 32'(a_tready), 1);

        // Basic 4-beat frame from the vector table
        for (int i = 0; i < 4; i++) begin
            beat(0, vecs[i].data, vecs[i].strb, vecs[i].last, i);
            chk($sformatf("v%0d_len", i), 32'(a_len), 32'(vecs[i].exp_len));
            chk($sformatf("v%0d_done", i), 32'(a_done), 32'(vecs[i].exp_done));
            chk($sformatf("v%0d_tready", i), 32'(a_tready), 32'(vecs[i].exp_tready));
            chk($sformatf("v%0d_ovf", i), 32'(a_ovf), 0);
        end
        for (int i = 0; i < 4; i++) rd(0, i);

        // Ack, single-beat frame, ack in IDLE ignored
        ack(0);
        chk("ack_tready", 32'(a_tready), 1);
        chk("ack_done", 32'(a_done), 0);
        chk("ack_len_hold", 32'(a_len), 4);
        beat(0, 32'hDEAD_BEEF, 4'hF, 1'b1, 0);
        chk("one_done", 32'(a_done), 1);
        chk("one_len", 32'(a_len), 1);
        chk("one_tready", 32'(a_tready), 0);
        rd(0, 0);
        ack(0);
        chk("one_ack_tready", 32'(a_tready), 1);
        ack(0);
        chk("idle_ack_tready", 32'(a_tready), 1);
        chk("idle_ack_done", 32'(a_done), 0);
        chk("idle_ack_len", 32'(a_len), 1);

        // Partial strobe merge; read of the same address on the write edge sees old data
        beat(0, 32'hFFFF_FFFF, 4'hF, 1'b1, 0);
        ack(0);
        a_rd_addr = '0;
        beat(0, 32'h1234_5678, 4'b0011, 1'b1, 0);
        chk("rd_during_wr_old", a_rd_data, 32'hFFFF_FFFF);
        rd(0, 0);
        chk("merge_const", mdl_a[0], 32'hFFFF_5678);
        ack(0);

        // TVALID gaps across a 5-beat frame, then TVALID held in DONE
        for (int i = 0; i < 5; i++) begin
            a_tvalid = 1'b0; tdata = 32'hBAD0_0000 + 32'(i);
            tick();
            beat(0, 32'hA000_0000 + 32'(i), 4'hF, i == 4, i);
            chk($sformatf("gap%0d_len", i), 32'(a_len), 32'(i + 1));
        end
        tdata = 32'h0BAD_0BAD; a_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("done_hold_len", 32'(a_len), 5);
            chk("done_hold_tready", 32'(a_tready), 0);
        end
        a_tvalid = 1'b0;
        for (int i = 0; i < 5; i++) rd(0, i);
        ack(0);

        // Overflow on the 4-word instance
        for (int i = 0; i < 6; i++) begin
            beat(1, 32'hB000_0000 + 32'(i), 4'hF, i == 5, i);
            chk($sformatf("b%0d_len", i), 32'(b_len), 32'(i < 4 ? i + 1 : 4));
            chk($sformatf("b%0d_ovf", i), 32'(b_ovf), 32'(i >= 4));
            chk($sformatf("b%0d_tready", i), 32'(b_tready), 32'(i < 5));
        end
        for (int i = 0; i < 4; i++) rd(1, i);
        ack(1);
        chk("b_ack_ovf_hold", 32'(b_ovf), 1);
        beat(1, 32'hB100_0000, 4'hF, 1'b1, 0);
        chk("b_next_ovf", 32'(b_ovf), 0);
        chk("b_next_len", 32'(b_len), 1);
        ack(1);

        // Reset mid-frame, then a clean 3-beat frame
        beat(0, 32'hC000_0000, 4'hF, 1'b0, 0);
        beat(0, 32'hC000_0001, 4'hF, 1'b0, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_tready", 32'(a_tready), 1);
        for (int i = 0; i < 3; i++) beat(0, 32'hE000_0000 + 32'(i), 4'hF, i == 2, i);
        chk("post_rst_len", 32'(a_len), 3);
        chk("post_rst_done", 32'(a_done), 1);
        for (int i = 0; i < 3; i++) rd(0, i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
